pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives write-enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles three cases: load-use (or RAW) hazards, taken branch/jump redirects resolved in EX, and data-memory wait states.
- Also keeps saturating performance counters for stall, flush and wait cycles.

Parameters:
- FLUSH_CYCLES, 1, cycles of IF/ID flush + ID/EX bubble per redirect; legal range 1-3.
- CNT_W, 16, width of each saturating performance counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- ID_rs_addr  in  5  rs of instruction in ID.
- ID_rt_addr  in  5  rt of instruction in ID.
- ID_uses_rs  in  1  ID instruction reads rs.
- ID_uses_rt  in  1  ID instruction reads rt.
- EX_rs_addr  in  5  rs held in ID/EX.
- EX_rt_addr  in  5  rt held in ID/EX.
- EX_WriteReg_addr  in  5  destination in EX.
- EX_RegWrite  in  1  EX instruction writes a register.
- EX_MemRead  in  1  EX instruction is a load.
- EX_Redirect  in  1  taken branch or jump resolved in EX this cycle.
- MEM_WriteReg_addr  in  5  destination in MEM.
- MEM_RegWrite  in  1  MEM instruction writes a register.
- MEM_MemAccess  in  1  MEM instruction is a load or store.
- DMem_ready  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC register load enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  IF/ID loads a NOP.
- IDEX_Write  out  1  ID/EX load enable.
- IDEX_Bubble  out  1  ID/EX loads all control bits zero.
- Back_Write  out  1  EX/MEM and MEM/WB load enable.
- ForwardA  out  2  ALU A source select (FORWARD_EN only).
- ForwardB  out  2  ALU B source select (FORWARD_EN only).
- Stall_Cnt  out  CNT_W  hazard stall cycles.
- Flush_Cnt  out  CNT_W  redirect flush cycles.
- Wait_Cnt  out  CNT_W  memory wait cycles.

Behaviour:
- Control outputs are combinational from state and inputs, so they take effect in the same cycle. State and counters are registered.

Reset:
- While RST=1, outputs are: PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Write=1, IDEX_Bubble=1, Back_Write=1, ForwardA/B=00.
- Posedge with RST=1: state<=RUN, flush counter<=0, all performance counters<=0.
- RST asserted mid-FLUSH or mid-MEMWAIT aborts that operation immediately.

Definitions:
- hazard(r) = r!=0 and r matches a qualifying producer. Register 0 never causes a hazard.
- wait = MEM_MemAccess & !DMem_ready.
- Default (no event): all *_Write=1, IFID_Flush=0, IDEX_Bubble=0.

States (priority within a cycle: wait > redirect > hazard stall):
- RUN, wait true:
  - PC_Write=0, IFID_Write=0, IDEX_Write=0, Back_Write=0.
  - Redirect and hazard are ignored.
  - Next state MEMWAIT; Wait_Cnt++.
- RUN, EX_Redirect:
  - PC_Write=1 (loads target), IFID_Flush=1, IDEX_Bubble=1.
  - If FLUSH_CYCLES>1, next state FLUSH with remaining=FLUSH_CYCLES-1.
  - Flush_Cnt++.
- RUN, hazard stall:
  - PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  - Stays in RUN; Stall_Cnt++.
- MEMWAIT:
  - Full freeze, same outputs as RUN-wait; Wait_Cnt++ each cycle wait holds.
  - When DMem_ready=1: Back_Write=1, that cycle is evaluated exactly as RUN, and state returns to RUN.
  - A redirect or hazard pending in EX/ID is held frozen and evaluated on the release cycle.
- FLUSH:
  - IFID_Flush=1, IDEX_Bubble=1, PC_Write=1; remaining-- each cycle; RUN when remaining reaches 0.
  - wait during FLUSH freezes as in MEMWAIT; remaining is held, and the block returns to FLUSH on release.
  - EX_Redirect during FLUSH is ignored (EX holds a bubble).

Counters:
- Each counter saturates at 2^CNT_W-1 and never wraps.

Optional Feature:
FORWARD_EN
- Defined:
  - Hazard stall only on load-use: EX_MemRead & EX_RegWrite & (ID_uses_rs&hazard_EX(ID_rs_addr) | ID_uses_rt&hazard_EX(ID_rt_addr)).
  - ForwardA/B (for EX_rs_addr/EX_rt_addr): 10 = EX/MEM result if MEM_RegWrite & match & r!=0; else 01 = MEM/WB result if the WB stage matches; else 00.
  - EX/MEM match has priority over MEM/WB.
  - WB match uses the MEM/WB destination, registered internally from MEM_* when Back_Write=1.
- Undefined:
  - ForwardA/B tied to 00.
  - Hazard stall on any RAW against EX (EX_RegWrite) or MEM (MEM_RegWrite) producers.
  - The register file is write-before-read, so WB never stalls.

Test Plan:
- RST high 2 cycles, then low -> during reset PC_Write=0, IFID_Flush=1, IDEX_Bubble=1; first cycle after reset all writes=1 and all counters=0.
- FORWARD_EN: EX lw to $8 (MemRead=1), ID add reads rs=$8 -> exactly 1 cycle with PC_Write=0, IDEX_Bubble=1; Stall_Cnt=1; next cycle ForwardA=01.
- Without FORWARD_EN: EX add writes $5, ID reads rt=$5 -> 2 stall cycles (EX, then MEM match); Stall_Cnt=2. Same test with destination $0 -> no stall.
- FLUSH_CYCLES=2, EX_Redirect pulse -> 2 consecutive cycles with IFID_Flush=1 and IDEX_Bubble=1; Flush_Cnt=2. A second EX_Redirect in cycle 2 is ignored.
- MEM_MemAccess=1 with DMem_ready low 3 cycles while EX_Redirect=1 -> 3 cycles all writes=0 and Wait_Cnt=3; redirect is acted on in the release cycle.
- Force 2^CNT_W+5 stall cycles (CNT_W=4) -> Stall_Cnt holds at 15 and never wraps.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use/RAW stalls, EX redirects,
// data-memory wait freezes and saturating event counters. Optional macro: FORWARD_EN.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ID_rs_addr,
    input  logic [4:0]       ID_rt_addr,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic [4:0]       EX_rs_addr,
    input  logic [4:0]       EX_rt_addr,
    input  logic [4:0]       EX_WriteReg_addr,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic             EX_Redirect,
    input  logic [4:0]       MEM_WriteReg_addr,
    input  logic             MEM_RegWrite,
    input  logic             MEM_MemAccess,
    input  logic             DMem_ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             Back_Write,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic [CNT_W-1:0] Wait_Cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic [1:0]       rem_r, rem_next_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r, wait_cnt_r;
    logic             stall_inc_s, flush_inc_s, wait_inc_s;
    logic             wait_s, flushing_s, hazard_s;

    function automatic logic reg_match(input logic we, input logic [4:0] dst, input logic [4:0] r);
        return we && (r != 5'd0) && (r == dst);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    assign wait_s = MEM_MemAccess & ~DMem_ready;
    // A freeze taken out of FLUSH keeps rem_r nonzero, so release resumes the flush.
    assign flushing_s = (state_r == FLUSH) || ((state_r == MEMWAIT) && (rem_r != 2'd0));

`ifdef FORWARD_EN
    logic [4:0] wb_dst_r;
    logic       wb_we_r;

    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic mem_we,
                                           input logic [4:0] mem_dst, input logic wb_we,
                                           input logic [4:0] wb_dst);
        if (reg_match(mem_we, mem_dst, r)) begin
            return 2'b10;
        end else if (reg_match(wb_we, wb_dst, r)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign hazard_s = EX_MemRead & EX_RegWrite &
                      ((ID_uses_rs & reg_match(1'b1, EX_WriteReg_addr, ID_rs_addr)) |
                       (ID_uses_rt & reg_match(1'b1, EX_WriteReg_addr, ID_rt_addr)));

    assign ForwardA = RST ? 2'b00 : fwd_sel(EX_rs_addr, MEM_RegWrite, MEM_WriteReg_addr, wb_we_r, wb_dst_r);
    assign ForwardB = RST ? 2'b00 : fwd_sel(EX_rt_addr, MEM_RegWrite, MEM_WriteReg_addr, wb_we_r, wb_dst_r);

    // MEM/WB destination shadow, advancing only when the back end advances.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_dst_r <= 5'd0;
            wb_we_r  <= 1'b0;
        end else if (Back_Write) begin
            wb_dst_r <= MEM_WriteReg_addr;
            wb_we_r  <= MEM_RegWrite;
        end
    end
`else
    logic unused_s;

    assign unused_s = ^{EX_rs_addr, EX_rt_addr, EX_MemRead};
    assign hazard_s = (ID_uses_rs & (reg_match(EX_RegWrite, EX_WriteReg_addr, ID_rs_addr) |
                                     reg_match(MEM_RegWrite, MEM_WriteReg_addr, ID_rs_addr))) |
                      (ID_uses_rt & (reg_match(EX_RegWrite, EX_WriteReg_addr, ID_rt_addr) |
                                     reg_match(MEM_RegWrite, MEM_WriteReg_addr, ID_rt_addr)));
    assign ForwardA = 2'b00;
    assign ForwardB = 2'b00;
`endif

    // Next-state and pipeline controls; priority is wait > flush/redirect > hazard.
    always_comb begin
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        Back_Write   = 1'b1;
        state_next_s = RUN;
        rem_next_s   = rem_r;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        wait_inc_s   = 1'b0;
        if (RST) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            rem_next_s  = 2'd0;
        end else if (wait_s) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            Back_Write   = 1'b0;
            state_next_s = MEMWAIT;
            wait_inc_s   = 1'b1;
        end else if (flushing_s) begin
            IFID_Flush   = 1'b1;
            IDEX_Bubble  = 1'b1;
            rem_next_s   = rem_r - 2'd1;
            state_next_s = (rem_r == 2'd1) ? RUN : FLUSH;
            flush_inc_s  = 1'b1;
        end else if (EX_Redirect) begin
            IFID_Flush   = 1'b1;
            IDEX_Bubble  = 1'b1;
            rem_next_s   = 2'(FLUSH_CYCLES - 1);
            state_next_s = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            flush_inc_s  = 1'b1;
        end else if (hazard_s) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            stall_inc_s = 1'b1;
        end else begin
            state_next_s = RUN;
        end
    end

    // State, flush remainder and saturating counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= RUN;
            rem_r       <= 2'd0;
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
            wait_cnt_r  <= '0;
        end else begin
            state_r     <= state_next_s;
            rem_r       <= rem_next_s;
            stall_cnt_r <= sat_inc(stall_cnt_r, stall_inc_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush_inc_s);
            wait_cnt_r  <= sat_inc(wait_cnt_r, wait_inc_s);
        end
    end

    assign Stall_Cnt = stall_cnt_r;
    assign Flush_Cnt = flush_cnt_r;
    assign Wait_Cnt  = wait_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level reference model of the sequencing rules.
module tb_pipe_hazard_ctrl;

    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic [4:0]    ID_rs_addr, ID_rt_addr, EX_rs_addr, EX_rt_addr;
    logic [4:0]    EX_WriteReg_addr, MEM_WriteReg_addr;
    logic          ID_uses_rs, ID_uses_rt, EX_RegWrite, EX_MemRead, EX_Redirect;
    logic          MEM_RegWrite, MEM_MemAccess, DMem_ready;
    logic          PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, Back_Write;
    logic [1:0]    ForwardA, ForwardB;
    logic [CW-1:0] Stall_Cnt, Flush_Cnt, Wait_Cnt;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .EX_rs_addr(EX_rs_addr), .EX_rt_addr(EX_rt_addr),
        .EX_WriteReg_addr(EX_WriteReg_addr), .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead), .EX_Redirect(EX_Redirect),
        .MEM_WriteReg_addr(MEM_WriteReg_addr), .MEM_RegWrite(MEM_RegWrite),
        .MEM_MemAccess(MEM_MemAccess), .DMem_ready(DMem_ready),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble), .Back_Write(Back_Write),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt), .Wait_Cnt(Wait_Cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       rst;
        bit [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wd, mem_wd;
        bit       uses_rs, uses_rt, ex_we, ex_mr, redir, mem_we, mem_acc, ready;
    } stim_t;

    // ctl bit order: PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, Back_Write
    typedef struct {
        bit [5:0] ctl;
        bit [1:0] fa, fb;
        int       stall, flush, wt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int       m_flush_left = 0, m_stall = 0, m_flush = 0, m_wait = 0;
    bit [4:0] m_wb_dst = 5'd0;
    bit       m_wb_we = 1'b0;

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        s.ready = 1'b1;
        return s;
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic bit [1:0] fsel(input bit [4:0] r, input stim_t s);
`ifdef FORWARD_EN
        if (r != 0 && s.mem_we && s.mem_wd == r) return 2'd2;
        if (r != 0 && m_wb_we && m_wb_dst == r) return 2'd1;
`endif
        return 2'd0;
    endfunction

    function automatic bit raw_hazard(input stim_t s);
        bit [4:0] src [2];
        bit       used [2];
        bit       h = 1'b0;
        src[0] = s.id_rs; used[0] = s.uses_rs;
        src[1] = s.id_rt; used[1] = s.uses_rt;
        for (int i = 0; i < 2; i++) begin
            if (used[i] && src[i] != 0) begin
`ifdef FORWARD_EN
                if (s.ex_mr && s.ex_we && s.ex_wd == src[i]) h = 1'b1;
`else
                if ((s.ex_we && s.ex_wd == src[i]) || (s.mem_we && s.mem_wd == src[i])) h = 1'b1;
`endif
            end
        end
        return h;
    endfunction

    task automatic model(input stim_t s);
        exp_t e;
        e.stall = m_stall; e.flush = m_flush; e.wt = m_wait;
        if (s.rst) begin
            e.ctl = 6'b001111; e.fa = 2'd0; e.fb = 2'd0;
            m_flush_left = 0; m_stall = 0; m_flush = 0; m_wait = 0;
            m_wb_dst = 5'd0; m_wb_we = 1'b0;
        end else begin
            e.fa = fsel(s.ex_rs, s);
            e.fb = fsel(s.ex_rt, s);
            if (s.mem_acc && !s.ready) begin
                e.ctl = 6'b000000;
                m_wait = sat(m_wait);
            end else begin
                if (m_flush_left > 0) begin
                    e.ctl = 6'b111111;
                    m_flush_left--;
                    m_flush = sat(m_flush);
                end else if (s.redir) begin
                    e.ctl = 6'b111111;
                    m_flush_left = FC - 1;
                    m_flush = sat(m_flush);
                end else if (raw_hazard(s)) begin
                    e.ctl = 6'b000111;
                    m_stall = sat(m_stall);
                end else begin
                    e.ctl = 6'b110101;
                end
                m_wb_dst = s.mem_wd;
                m_wb_we  = s.mem_we;
            end
        end
        q.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        RST = s.rst;
        ID_rs_addr = s.id_rs; ID_rt_addr = s.id_rt;
        ID_uses_rs = s.uses_rs; ID_uses_rt = s.uses_rt;
        EX_rs_addr = s.ex_rs; EX_rt_addr = s.ex_rt;
        EX_WriteReg_addr = s.ex_wd; EX_RegWrite = s.ex_we;
        EX_MemRead = s.ex_mr; EX_Redirect = s.redir;
        MEM_WriteReg_addr = s.mem_wd; MEM_RegWrite = s.mem_we;
        MEM_MemAccess = s.mem_acc; DMem_ready = s.ready;
    endtask

    task automatic apply(input stim_t s);
        @(posedge CLK);
        #1;
        drive(s);
        model(s);
    endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 5;
            if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, Back_Write} !== e.ctl) begin
                errors++;
                $display("FAIL ctl t=%0t got=%b want=%b", $time,
                         {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, Back_Write}, e.ctl);
            end
            if ({ForwardA, ForwardB} !== {e.fa, e.fb}) begin
                errors++;
                $display("FAIL fwd t=%0t got=%b/%b want=%b/%b", $time, ForwardA, ForwardB, e.fa, e.fb);
            end
            if ($isunknown(Stall_Cnt) || int'(Stall_Cnt) != e.stall) begin
                errors++;
                $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, Stall_Cnt, e.stall);
            end
            if ($isunknown(Flush_Cnt) || int'(Flush_Cnt) != e.flush) begin
                errors++;
                $display("FAIL flush_cnt t=%0t got=%0d want=%0d", $time, Flush_Cnt, e.flush);
            end
            if ($isunknown(Wait_Cnt) || int'(Wait_Cnt) != e.wt) begin
                errors++;
                $display("FAIL wait_cnt t=%0t got=%0d want=%0d", $time, Wait_Cnt, e.wt);
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        s = idle(); s.rst = 1'b1;
        drive(s);
        apply(s); apply(s);
        s = idle();
        apply(s); apply(s);
        // RAW on rt=$5 from an ALU producer, then the same with destination $0
        for (int d = 5; d >= 0; d -= 5) begin
            s = idle(); s.ex_we = 1; s.ex_wd = 5'(d); s.uses_rt = 1; s.id_rt = 5'(d);
            apply(s);
            s = idle(); s.mem_we = 1; s.mem_wd = 5'(d); s.uses_rt = 1; s.id_rt = 5'(d);
            apply(s);
            s = idle(); apply(s);
        end
        // load-use on $8, then the consumer reaches EX
        s = idle(); s.ex_we = 1; s.ex_mr = 1; s.ex_wd = 5'd8; s.uses_rs = 1; s.id_rs = 5'd8;
        apply(s);
        s = idle(); s.mem_we = 1; s.mem_wd = 5'd8; s.uses_rs = 1; s.id_rs = 5'd8;
        apply(s);
        s = idle(); s.ex_rs = 5'd8; apply(s);
        // redirect, second redirect during the flush
        s = idle(); s.redir = 1; apply(s); apply(s);
        s = idle(); apply(s);
        // memory wait for three cycles with a pending redirect
        s = idle(); s.mem_acc = 1; s.redir = 1;
        repeat (3) apply(s);
        s.ready = 1; apply(s);
        s = idle(); apply(s); apply(s);
        // wait arriving in the middle of a flush
        s = idle(); s.redir = 1; apply(s);
        s = idle(); s.mem_acc = 1; apply(s); apply(s);
        s = idle(); apply(s); apply(s);
        // reset aborting a flush and a wait
        s = idle(); s.redir = 1; apply(s);
        s = idle(); s.rst = 1; apply(s);
        s = idle(); s.mem_acc = 1; apply(s);
        s = idle(); s.rst = 1; apply(s);
        s = idle(); apply(s);
        // stall counter saturation
        s = idle(); s.ex_we = 1; s.ex_mr = 1; s.ex_wd = 5'd3; s.uses_rs = 1; s.id_rs = 5'd3;
        repeat ((1 << CW) + 5) apply(s);
        s = idle(); apply(s);
        // random traffic on a small register set so matches are frequent
        for (int n = 0; n < 1500; n++) begin
            s.rst     = ($urandom_range(0, 99) == 0);
            s.id_rs   = 5'($urandom_range(0, 3));
            s.id_rt   = 5'($urandom_range(0, 3));
            s.ex_rs   = 5'($urandom_range(0, 3));
            s.ex_rt   = 5'($urandom_range(0, 3));
            s.ex_wd   = 5'($urandom_range(0, 3));
            s.mem_wd  = 5'($urandom_range(0, 3));
            s.uses_rs = 1'($urandom_range(0, 1));
            s.uses_rt = 1'($urandom_range(0, 1));
            s.ex_we   = 1'($urandom_range(0, 1));
            s.ex_mr   = 1'($urandom_range(0, 1));
            s.mem_we  = 1'($urandom_range(0, 1));
            s.redir   = ($urandom_range(0, 5) == 0);
            s.mem_acc = ($urandom_range(0, 2) == 0);
            s.ready   = ($urandom_range(0, 2) != 0);
            apply(s);
        end
        s = idle(); apply(s);
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge CLK);
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain remaining=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
